// File: rtl/fill_pkg.sv
// Shared types, coordinate field positions and sizing helpers for the rectangle fill engine.
package fill_pkg;

  localparam int COORD_W = 12;
  localparam int X0_LSB  = 36;
  localparam int Y0_LSB  = 24;
  localparam int X1_LSB  = 12;
  localparam int Y1_LSB  = 0;

  typedef enum logic [1:0] {
    TEX_SOLID   = 2'b00,
    TEX_CHECK   = 2'b01,
    TEX_HSTRIPE = 2'b10,
    TEX_SKIP    = 2'b11
  } tex_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_READ,
    ST_WAIT,
    ST_WRITE,
    ST_NEXT,
    ST_DONE
  } state_e;

  function automatic int words_per_row(input int width, input int ppw);
    return (width + ppw - 1) / ppw;
  endfunction

endpackage

// File: rtl/fill_word_gen.sv
// Combinational per-word pixel mask and texture pattern for one SRAM word of a row.
// Zero latency; no handshake.
module fill_word_gen
  import fill_pkg::*;
#(
  parameter int PIXEL_BITS      = 24,
  parameter int PIXELS_PER_WORD = 64
) (
  input  logic [COORD_W-1:0]                    word_i,
  input  logic [COORD_W-1:0]                    y_i,
  input  logic [COORD_W-1:0]                    xl_i,
  input  logic [COORD_W-1:0]                    xr_i,
  input  logic [PIXEL_BITS-1:0]                 color_i,
  input  tex_e                                  tex_i,
  output logic [PIXELS_PER_WORD-1:0]            mask_o,
  output logic [PIXEL_BITS*PIXELS_PER_WORD-1:0] pattern_o,
  output logic                                  full_o
);

  for (genvar i = 0; i < PIXELS_PER_WORD; i++) begin : g_pix
    logic [COORD_W-1:0] x;
    logic               on;

    assign x         = word_i * COORD_W'(PIXELS_PER_WORD) + COORD_W'(i);
    assign mask_o[i] = (x >= xl_i) && (x <= xr_i);

    // checker: (x+y) even is the same as equal parities
    always_comb begin
      on = 1'b0;
      case (tex_i)
        TEX_SOLID:   on = 1'b1;
        TEX_CHECK:   on = ~(x[0] ^ y_i[0]);
        TEX_HSTRIPE: on = ~y_i[0];
        default:     on = 1'b0;
      endcase
    end

    assign pattern_o[i*PIXEL_BITS +: PIXEL_BITS] = on ? color_i : '0;
  end

  assign full_o = &mask_o;

endmodule

// File: rtl/fill_burst_engine.sv
// Fills a clipped rectangle into the SRAM frame store; full words written directly, partial words by RMW.
// Latency 1 setup + 2 cycles per full word / 4 per partial word + 1 done; start ignored while busy.
module fill_burst_engine
  import fill_pkg::*;
#(
  parameter int ADDR_SIZE_BITS  = 24,
  parameter int PIXEL_BITS      = 24,
  parameter int PIXELS_PER_WORD = 64,
  parameter int SCREEN_W        = 640,
  parameter int SCREEN_H        = 480,
  parameter int NUM_LAYERS      = 2,
  localparam int WORDS_PER_ROW  = words_per_row(SCREEN_W, PIXELS_PER_WORD),
  localparam int LW             = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1
) (
  input  logic                                  clk,
  input  logic                                  n_rst,
  input  logic                                  start,
  input  logic [4*COORD_W-1:0]                  coordinates,
  input  logic [1:0]                            texture_code,
  input  logic [PIXEL_BITS-1:0]                 color_code,
  input  logic [LW-1:0]                         layer_num,
  output logic                                  read_enable,
  output logic                                  write_enable,
  output logic [ADDR_SIZE_BITS-1:0]             address,
  input  logic [PIXEL_BITS*PIXELS_PER_WORD-1:0] read_data,
  output logic [PIXEL_BITS*PIXELS_PER_WORD-1:0] write_data,
  output logic                                  busy,
  output logic                                  fill_done,
  output logic                                  clip_error
);

  localparam int WPW = PIXEL_BITS * PIXELS_PER_WORD;
  localparam logic [COORD_W-1:0] SW_C  = COORD_W'(SCREEN_W);
  localparam logic [COORD_W-1:0] SH_C  = COORD_W'(SCREEN_H);
  localparam logic [COORD_W-1:0] XMAX  = COORD_W'(SCREEN_W - 1);
  localparam logic [COORD_W-1:0] YMAX  = COORD_W'(SCREEN_H - 1);
  localparam logic [COORD_W-1:0] PPW_C = COORD_W'(PIXELS_PER_WORD);
  localparam logic [ADDR_SIZE_BITS-1:0] ROW_WORDS   = ADDR_SIZE_BITS'(WORDS_PER_ROW);
  localparam logic [ADDR_SIZE_BITS-1:0] LAYER_WORDS = ADDR_SIZE_BITS'(WORDS_PER_ROW * SCREEN_H);

  state_e                    state_q, state_d;
  logic [4*COORD_W-1:0]      coord_q;
  tex_e                      tex_q;
  logic [PIXEL_BITS-1:0]     color_q;
  logic [LW-1:0]             layer_q;
  logic [COORD_W-1:0]        xl_q, xr_q, y_q, yb_q, wl_q, wr_q, word_q;
  logic [ADDR_SIZE_BITS-1:0] row_q;
  logic                      clip_q;
  logic [WPW-1:0]            rd_q;

  logic [COORD_W-1:0]        x0, y0, x1, y1, xl_s, xr_s, yt_s, yb_s, wl_s, wr_s;
  logic                      off_s;
  logic [ADDR_SIZE_BITS-1:0] row_s;

  always_comb begin
    x0    = coord_q[X0_LSB +: COORD_W];
    y0    = coord_q[Y0_LSB +: COORD_W];
    x1    = coord_q[X1_LSB +: COORD_W];
    y1    = coord_q[Y1_LSB +: COORD_W];
    xl_s  = (x0 <= x1) ? x0 : x1;
    xr_s  = (x0 <= x1) ? x1 : x0;
    yt_s  = (y0 <= y1) ? y0 : y1;
    yb_s  = (y0 <= y1) ? y1 : y0;
    if (xr_s > XMAX) xr_s = XMAX;
    if (yb_s > YMAX) yb_s = YMAX;
    off_s = (xl_s >= SW_C) || (yt_s >= SH_C);
    wl_s  = xl_s / PPW_C;
    wr_s  = xr_s / PPW_C;
    row_s = ADDR_SIZE_BITS'(layer_q) * LAYER_WORDS + ADDR_SIZE_BITS'(yt_s) * ROW_WORDS;
  end

  logic               last_word, last_row;
  logic [COORD_W-1:0] nword, ny;

  assign last_word = (word_q == wr_q);
  assign last_row  = (y_q == yb_q);
  assign nword     = last_word ? wl_q : word_q + COORD_W'(1);
  assign ny        = last_word ? y_q + COORD_W'(1) : y_q;

  // The generator looks ahead in SETUP/NEXT so the full flag picks the next word's path.
  logic [COORD_W-1:0] gen_word, gen_y, gen_xl, gen_xr;

  always_comb begin
    gen_word = word_q;
    gen_y    = y_q;
    gen_xl   = xl_q;
    gen_xr   = xr_q;
    case (state_q)
      ST_SETUP: begin
        gen_word = wl_s;
        gen_y    = yt_s;
        gen_xl   = xl_s;
        gen_xr   = xr_s;
      end
      ST_NEXT: begin
        gen_word = nword;
        gen_y    = ny;
      end
      default: ;
    endcase
  end

  logic [PIXELS_PER_WORD-1:0] mask;
  logic [WPW-1:0]             pattern;
  logic                       full;

  fill_word_gen #(
    .PIXEL_BITS     (PIXEL_BITS),
    .PIXELS_PER_WORD(PIXELS_PER_WORD)
  ) u_word_gen (
    .word_i   (gen_word),
    .y_i      (gen_y),
    .xl_i     (gen_xl),
    .xr_i     (gen_xr),
    .color_i  (color_q),
    .tex_i    (tex_q),
    .mask_o   (mask),
    .pattern_o(pattern),
    .full_o   (full)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (start) state_d = ST_SETUP;
      ST_SETUP: begin
        if (off_s || (tex_q == TEX_SKIP)) state_d = ST_DONE;
        else                              state_d = full ? ST_WRITE : ST_READ;
      end
      ST_READ:  state_d = ST_WAIT;
      ST_WAIT:  state_d = ST_WRITE;
      ST_WRITE: state_d = ST_NEXT;
      ST_NEXT: begin
        if (last_word && last_row) state_d = ST_DONE;
        else                       state_d = full ? ST_WRITE : ST_READ;
      end
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      coord_q <= '0;
      tex_q   <= TEX_SOLID;
      color_q <= '0;
      layer_q <= '0;
      xl_q    <= '0;
      xr_q    <= '0;
      y_q     <= '0;
      yb_q    <= '0;
      wl_q    <= '0;
      wr_q    <= '0;
      word_q  <= '0;
      row_q   <= '0;
      clip_q  <= 1'b0;
      rd_q    <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            coord_q <= coordinates;
            tex_q   <= tex_e'(texture_code);
            color_q <= color_code;
            layer_q <= layer_num;
          end
        end
        ST_SETUP: begin
          xl_q   <= xl_s;
          xr_q   <= xr_s;
          y_q    <= yt_s;
          yb_q   <= yb_s;
          wl_q   <= wl_s;
          wr_q   <= wr_s;
          word_q <= wl_s;
          row_q  <= row_s;
          clip_q <= off_s;
        end
        ST_WAIT: rd_q <= read_data;
        ST_NEXT: begin
          word_q <= nword;
          if (last_word) begin
            y_q   <= ny;
            row_q <= row_q + ROW_WORDS;
          end
        end
        default: ;
      endcase
    end
  end

  logic [WPW-1:0] merged;

  for (genvar i = 0; i < PIXELS_PER_WORD; i++) begin : g_merge
    assign merged[i*PIXEL_BITS +: PIXEL_BITS] = mask[i] ? pattern[i*PIXEL_BITS +: PIXEL_BITS]
                                                        : rd_q[i*PIXEL_BITS +: PIXEL_BITS];
  end

  assign read_enable  = (state_q == ST_READ);
  assign write_enable = (state_q == ST_WRITE);
  assign address      = row_q + ADDR_SIZE_BITS'(word_q);
  assign write_data   = (state_q == ST_WRITE) ? merged : '0;
  assign busy         = (state_q != ST_IDLE);
  assign fill_done    = (state_q == ST_DONE);
  assign clip_error   = (state_q == ST_DONE) && clip_q;

endmodule
